// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester/memory bus bundle for mem_port_arbiter
// Also holds the write-width type shared by the requester and memory sides.
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    write_byte = 2'd0,
    write_half = 2'd1,
    write_word = 2'd2
  } write_width_t;
endpackage

interface mem_port_arbiter_if #(parameter int XLEN = 32);
  import mem_port_arbiter_pkg::*;

  logic            req0;
  logic [XLEN-1:0] addr0;
  logic            req1;
  logic [XLEN-1:0] addr1;
  logic            we1;
  logic [XLEN-1:0] wdata1;
  write_width_t    wwidth1;
  logic            gnt0;
  logic            gnt1;
  logic            rvalid0;
  logic            rvalid1;
  logic [XLEN-1:0] rdata0;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] mem_addr;
  logic            mem_w_enable;
  logic [XLEN-1:0] mem_w_data;
  write_width_t    mem_w_width;
  logic [XLEN-1:0] mem_r_data;

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, wwidth1, mem_r_data,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_w_enable, mem_w_data, mem_w_width
  );

  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, wwidth1, mem_r_data,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_addr, mem_w_enable, mem_w_data, mem_w_width
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for one sync-read memory
// Optional grant/conflict counters are enabled with MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   BASE_ADDR = 32'h00020000
) (
  input  logic                 clock,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_gnt0,
  output logic [31:0]          perf_gnt1,
  output logic [31:0]          perf_conflict
`endif
);
  logic last_gnt, rsp_pending, rsp_owner;
  logic last_gnt_d, rsp_pending_d, rsp_owner_d;
  logic grant0, grant1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt    <= 1'b1;
      rsp_pending <= 1'b0;
      rsp_owner   <= 1'b0;
    end else begin
      last_gnt    <= last_gnt_d;
      rsp_pending <= rsp_pending_d;
      rsp_owner   <= rsp_owner_d;
    end
  end

  // Writes are acknowledged by the grant itself, so only reads leave a response pending.
  always_comb begin
    last_gnt_d    = last_gnt;
    rsp_pending_d = 1'b0;
    rsp_owner_d   = rsp_owner;
    if (grant0 || grant1) begin
      last_gnt_d    = grant1;
      rsp_pending_d = grant0 || !bus.we1;
      rsp_owner_d   = grant1;
    end
  end

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        grant0 = last_gnt;
        grant1 = !last_gnt;
      end else begin
        grant0 = bus.req0;
        grant1 = bus.req1;
      end
    end
    bus.gnt0         = grant0;
    bus.gnt1         = grant1;
    bus.mem_addr     = (grant1 ? bus.addr1 : bus.addr0) - BASE_ADDR;
    bus.mem_w_enable = grant1 && bus.we1;
    bus.mem_w_data   = bus.wdata1;
    bus.mem_w_width  = bus.wwidth1;
    // Gating with reset drops a read that was granted just before reset.
    bus.rvalid0      = !reset && rsp_pending && !rsp_owner;
    bus.rvalid1      = !reset && rsp_pending && rsp_owner;
    bus.rdata0       = bus.mem_r_data;
    bus.rdata1       = bus.mem_r_data;
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_gnt0     <= 32'd0;
      perf_gnt1     <= 32'd0;
      perf_conflict <= 32'd0;
    end else begin
      if (grant0 && perf_gnt0 != 32'hFFFFFFFF)
        perf_gnt0 <= perf_gnt0 + 32'd1;
      if (grant1 && perf_gnt1 != 32'hFFFFFFFF)
        perf_gnt1 <= perf_gnt1 + 32'd1;
      if (bus.req0 && bus.req1 && perf_conflict != 32'hFFFFFFFF)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter with a reference model
// Memory is modelled as a hash of the address so every read returns distinct data.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] BASE = 32'h00020000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_port_arbiter_if #(.XLEN(32)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

  mem_port_arbiter #(.XLEN(32), .BASE_ADDR(BASE)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_gnt0(perf_gnt0),
    .perf_gnt1(perf_gnt1),
    .perf_conflict(perf_conflict)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  always @(posedge clock) bus.mem_r_data <= mem_f(bus.mem_addr);

  // Reference state: which port was served last and the read response owed next cycle.
  bit          m_last = 1'b1;
  bit          m_rsp = 1'b0;
  bit          m_owner = 1'b0;
  logic [31:0] m_rdata = 32'd0;
  longint      m_pg0 = 0, m_pg1 = 0, m_pc = 0;
  bit          eg0, eg1;

  task automatic cycle();
    bit w1;
    logic [31:0] a0, a1;
    @(negedge clock);
    a0 = bus.addr0 - BASE;
    a1 = bus.addr1 - BASE;
    if (reset) begin
      eg0 = 1'b0; eg1 = 1'b0;
    end else if (bus.req0 && bus.req1) begin
      eg1 = (m_last == 1'b0);
      eg0 = !eg1;
    end else begin
      eg0 = bus.req0; eg1 = bus.req1;
    end
    w1 = eg1 && bus.we1;
    check("gnt0", bus.gnt0, eg0);
    check("gnt1", bus.gnt1, eg1);
    check("rvalid0", bus.rvalid0, !reset && m_rsp && !m_owner);
    check("rvalid1", bus.rvalid1, !reset && m_rsp && m_owner);
    if (!reset && m_rsp && !m_owner) check("rdata0", bus.rdata0, m_rdata);
    if (!reset && m_rsp && m_owner) check("rdata1", bus.rdata1, m_rdata);
    check("mem_w_enable", bus.mem_w_enable, w1);
    if (eg0) check("mem_addr0", bus.mem_addr, a0);
    if (eg1) check("mem_addr1", bus.mem_addr, a1);
    if (w1) begin
      check("mem_w_data", bus.mem_w_data, bus.wdata1);
      check("mem_w_width", bus.mem_w_width, bus.wwidth1);
    end
    if (reset) begin
      m_last = 1'b1; m_rsp = 1'b0; m_owner = 1'b0;
      m_pg0 = 0; m_pg1 = 0; m_pc = 0;
    end else begin
      if (bus.req0 && bus.req1) m_pc++;
      if (eg0 || eg1) begin
        m_last  = eg1;
        m_rsp   = !w1;
        m_owner = eg1;
        m_rdata = mem_f(eg1 ? a1 : a0);
        if (eg0) m_pg0++; else m_pg1++;
      end else begin
        m_rsp = 1'b0;
      end
    end
    @(posedge clock);
    #1;
`ifdef MEM_ARB_PERF_CNT_EN
    check("perf_gnt0", perf_gnt0, m_pg0);
    check("perf_gnt1", perf_gnt1, m_pg1);
    check("perf_conflict", perf_conflict, m_pc);
`endif
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return $urandom;
    return BASE + ($urandom & 32'h0000FFFC);
  endfunction

  task automatic new_req0(input bit force_req);
    bus.req0  = force_req || ($urandom_range(0, 3) != 0);
    bus.addr0 = rand_addr();
  endtask

  task automatic new_req1(input bit force_req, input bit allow_write);
    bus.req1    = force_req || ($urandom_range(0, 3) != 0);
    bus.addr1   = rand_addr();
    bus.we1     = allow_write && $urandom_range(0, 1) == 1;
    bus.wdata1  = $urandom;
    bus.wwidth1 = write_width_t'($urandom_range(0, 2));
  endtask

  task automatic idle();
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we1 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    bus.addr0 = BASE; bus.addr1 = BASE; bus.wdata1 = '0; bus.wwidth1 = write_word;
    do_reset();
    cycle();

    // Lone fetch read and its response.
    bus.req0 = 1'b1; bus.addr0 = 32'h00020010;
    cycle();
    idle();
    cycle();

    // Both ports reading every cycle: strict alternation starting at port 0.
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = rand_addr(); bus.addr1 = rand_addr();
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (eg0) bus.addr0 = rand_addr();
      if (eg1) bus.addr1 = rand_addr();
    end
    idle();
    cycle();

    // Port 1 word write: no response afterwards.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 32'h00020004;
    bus.wdata1 = 32'hDEADBEEF; bus.wwidth1 = write_word;
    cycle();
    idle();
    cycle();

    // Read granted, then reset: no response, port 0 wins the next conflict.
    bus.req1 = 1'b1; bus.addr1 = 32'h00020020;
    cycle();
    idle();
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    cycle();
    idle();
    cycle();

    // Port 1 alone three times, then a conflict goes to port 0.
    do_reset();
    bus.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.addr1 = rand_addr();
      cycle();
    end
    bus.req0 = 1'b1; bus.addr0 = rand_addr();
    cycle();
    idle();
    cycle();

    // Five conflict cycles from reset.
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    idle();
    cycle();

    // Randomized traffic with occasional resets.
    idle();
    for (int i = 0; i < 3000; i++) begin
      if (eg0 || !bus.req0) new_req0(1'b0);
      if (eg1 || !bus.req1) new_req1(1'b0, 1'b1);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read memory between two requesters: port 0 = instruction fetch, port 1 = data load/store.
- Sits between the fetch/load/store stages and the ram/rom instance so that a pipelined core can issue fetch and data accesses in the same cycle.
- Arbitration is round-robin.
- Read data is routed back to the requester that issued the read, one cycle after its grant.

Parameters:
- XLEN, 32, address/data width.
- BASE_ADDR, 32'h00020000, subtracted from the winning address before it drives mem_addr.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until granted
- addr0  in  XLEN  port 0 byte address
- req1  in  1  port 1 request; held until granted
- addr1  in  XLEN  port 1 byte address
- we1  in  1  port 1 write (1) / read (0)
- wdata1  in  XLEN  port 1 write data
- wwidth1  in  write_width_t  port 1 write width
- gnt0, gnt1  out  1  combinational grant, same cycle as request
- rvalid0, rvalid1  out  1  read data valid, registered
- rdata0, rdata1  out  XLEN  read data; equals mem_r_data while the matching rvalid is high
- mem_addr  out  XLEN  winner address minus BASE_ADDR
- mem_w_enable  out  1  memory write strobe
- mem_w_data  out  XLEN  memory write data
- mem_w_width  out  write_width_t  memory write width
- mem_r_data  in  XLEN  memory read data, valid the cycle after address

Behaviour:
- State: last_gnt (1 bit: port last granted), rsp_pending (1 bit), rsp_owner (1 bit).
- Reset values: last_gnt=1 (port 0 wins the first conflict), rsp_pending=0, rsp_owner=0.
- Reset effect on outputs: rvalid0=rvalid1=0 in the cycle after reset. gnt0/gnt1 are forced 0 while reset=1. mem_w_enable=0 while reset=1.
- Arbitration:
  - Only req0: gnt0=1.
  - Only req1: gnt1=1.
  - Both: the port not equal to last_gnt wins.
  - Neither: no grant, mem_w_enable=0, mem_addr='x (don't care).
  - At most one grant per cycle.
- last_gnt updates on the clock edge to the granted port whenever a grant occurs; otherwise it holds.
- Memory drive: the winner's addr, wdata, wwidth and we go to memory. Port 0 is always a read (mem_w_enable=0 for port 0).
- Write grant: mem_w_enable=1 that cycle. No response, rsp_pending<=0. The grant itself is the write acknowledge.
- Read grant: rsp_pending<=1, rsp_owner<=winner. The next cycle rvalid[rsp_owner]=1 and rdata[rsp_owner]=mem_r_data; the other rvalid=0.
- Back-to-back throughput: a new grant is allowed in the same cycle an earlier read's rvalid is high, giving 1 access/cycle sustained.
- Requester rules:
  - After gnt=0 the requester keeps req, addr and data stable.
  - After gnt=1 it may drop req or present a new request next cycle.
  - The arbiter does not check these rules.
- Simultaneous requests every cycle: grants strictly alternate 0,1,0,1.
- A single requester continuously requesting is granted every cycle, whatever last_gnt holds.
- Reset mid-read: a read granted in the cycle before reset produces no rvalid. rsp_pending clears and no stale data is delivered.
- Address wrap: subtraction is modulo 2^XLEN. No range check is performed.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds outputs perf_gnt0, perf_gnt1 and perf_conflict, each 32 bits and registered:
  - perf_gnt0 / perf_gnt1: count grants per port.
  - perf_conflict: counts cycles with req0 && req1.
  - All counters reset to 0 and saturate at 32'hFFFFFFFF (no wrap).
- When undefined, these ports and counters do not exist. Arbitration behaviour is identical either way.

Test Plan:
- Reset, then req0=1 addr0=32'h00020010 alone → gnt0=1, mem_addr=32'h10 same cycle; next cycle rvalid0=1, rdata0=mem_r_data, rvalid1=0.
- req0 and req1 both held high (read) for 4 cycles after reset → gnt sequence 0,1,0,1; rvalid sequence one cycle later 0,1,0,1, each with its own data.
- req1=1 we1=1 addr1=32'h00020004 wdata1=32'hDEADBEEF wwidth1=write_word → gnt1=1, mem_w_enable=1, mem_addr=32'h4, mem_w_data=32'hDEADBEEF; no rvalid1 the following cycle.
- Port 1 read granted, reset asserted the next cycle → rvalid0=rvalid1=0 throughout reset; the first conflict after reset is granted to port 0.
- req1 alone for 3 cycles then both → gnt1 ×3, then gnt0 (last_gnt=1).
- With MEM_ARB_PERF_CNT_EN: 5 conflict cycles → perf_conflict=5, perf_gnt0+perf_gnt1=5; force the counter to 32'hFFFFFFFF → stays 32'hFFFFFFFF.
